// File: rtl/bht_update_queue.sv
// In-flight branch queue between fetch/execute and the local BHT write port.
// Pops the oldest branch on resolve, trains the BHT, flags mispredicts and squashes younger entries.
module bht_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic [15:0]              enq_pc,
  input  logic                     enq_prediction,
  output logic                     enq_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     bht_write,
  output logic [15:0]              bht_write_pc,
  output logic                     bht_taken,
  output logic                     mispredict,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              branch_count,
  output logic [15:0]              mispredict_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [15:0]   pc_mem   [DEPTH];
  logic          pred_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic          do_res;
  logic          do_enq;
  logic          squash;
  logic [15:0]   head_pc;
  logic          head_pred;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign enq_ready = !full;

  // Accept decisions use the registered status, so a same-cycle enqueue never frees or fills a slot for a resolve.
  always_comb begin
    head_pc   = pc_mem[head];
    head_pred = pred_mem[head];
    do_res    = resolve_valid && !empty;
    squash    = do_res && (head_pred != resolve_taken);
    do_enq    = enq_valid && !full && !squash;
  end

  always_ff @(posedge clk) begin
    if (!reset && do_enq) begin
      pc_mem[tail]   <= enq_pc;
      pred_mem[tail] <= enq_prediction;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      bht_write    <= 1'b0;
      bht_write_pc <= 16'h0000;
      bht_taken    <= 1'b0;
      mispredict   <= 1'b0;
    end else begin
      bht_write  <= do_res;
      mispredict <= squash;
      if (do_res) begin
        bht_write_pc <= head_pc;
        bht_taken    <= resolve_taken;
        head         <= head + PTR_ONE;
      end
      // A squash discards everything younger than the popped head, including this cycle's enqueue.
      if (squash) begin
        tail  <= head + PTR_ONE;
        count <= '0;
      end else begin
        if (do_enq) begin
          tail <= tail + PTR_ONE;
        end
        case ({do_enq, do_res})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= 16'h0000;
      mispredict_count <= 16'h0000;
    end else begin
      if (do_res && (branch_count != 16'hFFFF)) begin
        branch_count <= branch_count + 16'h0001;
      end
      if (squash && (mispredict_count != 16'hFFFF)) begin
        mispredict_count <= mispredict_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue: a scoreboard holds the BHT writes each resolve should cause,
// and a negedge monitor pops and compares them whenever bht_write is seen.
module tb_bht_update_queue;

  logic        clk;
  logic        reset;
  logic        enq_valid;
  logic [15:0] enq_pc;
  logic        enq_prediction;
  logic        enq_ready;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        bht_write;
  logic [15:0] bht_write_pc;
  logic        bht_taken;
  logic        mispredict;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
    logic        mis;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  bht_update_queue #(.DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .enq_valid        (enq_valid),
    .enq_pc           (enq_pc),
    .enq_prediction   (enq_prediction),
    .enq_ready        (enq_ready),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .bht_write        (bht_write),
    .bht_write_pc     (bht_write_pc),
    .bht_taken        (bht_taken),
    .mispredict       (mispredict),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic expectWrite(input logic [15:0] pc, input logic taken, input logic mis);
    expQ.push_back('{pc: pc, taken: taken, mis: mis});
  endtask

  // Drive one cycle of inputs, let the edge happen, then return just after it with inputs idle.
  task automatic applyStimulus(input logic ev, input logic [15:0] pc, input logic pred,
                               input logic rv, input logic taken);
    enq_valid      = ev;
    enq_pc         = pc;
    enq_prediction = pred;
    resolve_valid  = rv;
    resolve_taken  = taken;
    @(posedge clk);
    #1;
    enq_valid     = 1'b0;
    resolve_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bht_write) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_write: got pc %0h, expected no write at %0t", bht_write_pc, $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("write_pc", 32'(bht_write_pc), 32'(e.pc));
        checkOutput("write_taken", 32'(bht_taken), 32'(e.taken));
        checkOutput("write_mispredict", 32'(mispredict), 32'(e.mis));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] pcs [4];
    pcs[0] = 16'h3000; pcs[1] = 16'h3002; pcs[2] = 16'h3004; pcs[3] = 16'h3006;

    // Reset held with both request inputs active.
    reset          = 1'b1;
    enq_valid      = 1'b1;
    enq_pc         = 16'h5555;
    enq_prediction = 1'b1;
    resolve_valid  = 1'b1;
    resolve_taken  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_enq_ready", 32'(enq_ready), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_bht_write", 32'(bht_write), 0);
    checkOutput("rst_mispredict", 32'(mispredict), 0);
    checkOutput("rst_write_pc", 32'(bht_write_pc), 0);
    checkOutput("rst_branch_count", 32'(branch_count), 0);
    checkOutput("rst_mis_count", 32'(mispredict_count), 0);
    reset         = 1'b0;
    enq_valid     = 1'b0;
    resolve_valid = 1'b0;

    // Correct prediction round trip.
    applyStimulus(1, 16'h1000, 1, 0, 0);
    checkOutput("cp_count", 32'(count), 1);
    checkOutput("cp_empty_before", 32'(empty), 0);
    expectWrite(16'h1000, 1, 0);
    applyStimulus(0, 16'h0000, 0, 1, 1);
    checkOutput("cp_bht_write", 32'(bht_write), 1);
    checkOutput("cp_write_pc", 32'(bht_write_pc), 32'h1000);
    checkOutput("cp_taken", 32'(bht_taken), 1);
    checkOutput("cp_mispredict", 32'(mispredict), 0);
    checkOutput("cp_branch_count", 32'(branch_count), 1);
    checkOutput("cp_empty", 32'(empty), 1);
    applyStimulus(0, 16'h0000, 0, 0, 0);
    checkOutput("cp_write_pulse", 32'(bht_write), 0);

    // Fill to the boundary, drop an extra entry, drain with one surplus resolve; three rounds wrap the pointers.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) applyStimulus(1, pcs[i], r[0], 0, 0);
      checkOutput("fill_full", 32'(full), 1);
      checkOutput("fill_enq_ready", 32'(enq_ready), 0);
      applyStimulus(1, 16'h3008, r[0], 0, 0);
      checkOutput("fill_drop_count", 32'(count), 4);
      for (int i = 0; i < 4; i++) begin
        expectWrite(pcs[i], r[0], 0);
        applyStimulus(0, 16'h0000, 0, 1, r[0]);
        checkOutput("drain_write", 32'(bht_write), 1);
      end
      applyStimulus(0, 16'h0000, 0, 1, r[0]);
      checkOutput("drain_extra_write", 32'(bht_write), 0);
      checkOutput("drain_empty", 32'(empty), 1);
      checkOutput("drain_branch_count", 32'(branch_count), 32'(1 + 4 * (r + 1)));
    end

    // Mispredict squashes younger entries and the same-cycle enqueue.
    applyStimulus(1, 16'h2000, 0, 0, 0);
    applyStimulus(1, 16'h2002, 1, 0, 0);
    applyStimulus(1, 16'h2004, 1, 0, 0);
    checkOutput("sq_count_before", 32'(count), 3);
    expectWrite(16'h2000, 1, 1);
    applyStimulus(1, 16'h2006, 1, 1, 1);
    checkOutput("sq_mispredict", 32'(mispredict), 1);
    checkOutput("sq_write_pc", 32'(bht_write_pc), 32'h2000);
    checkOutput("sq_taken", 32'(bht_taken), 1);
    checkOutput("sq_count", 32'(count), 0);
    checkOutput("sq_empty", 32'(empty), 1);
    checkOutput("sq_mis_count", 32'(mispredict_count), 1);
    checkOutput("sq_branch_count", 32'(branch_count), 14);
    applyStimulus(0, 16'h0000, 0, 1, 1);
    checkOutput("sq_absent_write", 32'(bht_write), 0);
    checkOutput("sq_mispredict_pulse", 32'(mispredict), 0);
    checkOutput("sq_absent_branch_count", 32'(branch_count), 14);

    // Simultaneous enqueue and matching resolve keep the count.
    applyStimulus(1, 16'h4000, 1, 0, 0);
    applyStimulus(1, 16'h4002, 0, 0, 0);
    expectWrite(16'h4000, 1, 0);
    applyStimulus(1, 16'h4004, 1, 1, 1);
    checkOutput("sim_count", 32'(count), 2);
    checkOutput("sim_write", 32'(bht_write), 1);
    checkOutput("sim_write_pc", 32'(bht_write_pc), 32'h4000);
    expectWrite(16'h4002, 0, 0);
    applyStimulus(0, 16'h0000, 0, 1, 0);
    expectWrite(16'h4004, 1, 0);
    applyStimulus(0, 16'h0000, 0, 1, 1);
    checkOutput("sim_last_pc", 32'(bht_write_pc), 32'h4004);
    checkOutput("sim_empty", 32'(empty), 1);
    checkOutput("sim_branch_count", 32'(branch_count), 17);

    // Enqueue into an empty queue cannot be resolved in the same cycle.
    applyStimulus(1, 16'h6000, 1, 1, 1);
    checkOutput("ee_no_write", 32'(bht_write), 0);
    checkOutput("ee_count", 32'(count), 1);
    expectWrite(16'h6000, 1, 0);
    applyStimulus(0, 16'h0000, 0, 1, 1);
    checkOutput("ee_branch_count", 32'(branch_count), 18);

    // Reset in the middle of operation with a resolve pending.
    applyStimulus(1, 16'h7000, 1, 0, 0);
    applyStimulus(1, 16'h7002, 1, 0, 0);
    applyStimulus(1, 16'h7004, 1, 0, 0);
    checkOutput("mr_count_before", 32'(count), 3);
    reset = 1'b1;
    applyStimulus(0, 16'h0000, 0, 1, 1);
    reset = 1'b0;
    checkOutput("mr_bht_write", 32'(bht_write), 0);
    checkOutput("mr_mispredict", 32'(mispredict), 0);
    checkOutput("mr_empty", 32'(empty), 1);
    checkOutput("mr_branch_count", 32'(branch_count), 0);
    checkOutput("mr_mis_count", 32'(mispredict_count), 0);
    applyStimulus(0, 16'h0000, 0, 1, 1);
    checkOutput("mr_no_stale_write", 32'(bht_write), 0);
    applyStimulus(1, 16'h7100, 0, 0, 0);
    expectWrite(16'h7100, 0, 0);
    applyStimulus(0, 16'h0000, 0, 1, 0);
    checkOutput("mr_fresh_branch_count", 32'(branch_count), 1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Tracks every branch for which the local BHT supplied a prediction, from fetch until execute resolves it. It sits between fetch/execute and the BHT write port and drives `write`, `write_pc` and `taken` into the predictor. It also raises a one-cycle mispredict pulse so the pipeline can redirect, and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- DEPTH, default 4: in-flight branch entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  fetch has a predicted branch to record this cycle.
- enq_pc  in  16 (lc3b_word)  PC of that branch.
- enq_prediction  in  1  BHT prediction used at fetch (1 = taken).
- enq_ready  out  1  queue can accept an entry; equals !full.
- resolve_valid  in  1  execute resolved the oldest outstanding branch.
- resolve_taken  in  1  actual outcome of that branch.
- bht_write  out  1  write strobe to the BHT.
- bht_write_pc  out  16  PC to update; wired to the BHT `write_pc`.
- bht_taken  out  1  outcome to train with; wired to the BHT `taken`.
- mispredict  out  1  one-cycle pulse: resolved outcome differed from the stored prediction.
- empty, full  out  1 each  queue status.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- branch_count  out  16  saturating count of resolved branches.
- mispredict_count  out  16  saturating count of mispredicts.

## Operation
- Storage is a circular FIFO of {pc[15:0], prediction}, with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate `count`.
- Enqueue is accepted when `enq_valid && !full && !squash`.
  - The entry is written at tail, then tail and count advance.
  - If the queue is full, the entry is dropped, even if a resolve frees a slot in the same cycle.
- Resolve is accepted when `resolve_valid && !empty`, with `empty` evaluated before the edge.
  - The head entry is popped.
  - `bht_write`, `bht_write_pc` = head.pc and `bht_taken` = `resolve_taken` are registered.
  - `mispredict` is registered as (head.prediction != resolve_taken).
  - `branch_count` increments.
- A resolve with the queue empty is ignored: no write, no counter change.
- Squash: `squash` = accepted resolve with mismatch.
  - All younger entries are discarded: tail = head+1, count = 0.
  - An enqueue in the same cycle is wrong-path and is dropped.
  - `mispredict_count` increments.
- Simultaneous enqueue and resolve with no squash: both happen and count is unchanged.
- Enqueue into an empty queue cannot be resolved in the same cycle; the entry becomes visible at head next cycle.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset values:
  - `bht_write` = 0, `mispredict` = 0.
  - `bht_write_pc` = 16'h0000, `bht_taken` = 0.
  - `count` = 0, `empty` = 1, `full` = 0, `enq_ready` = 1.
  - Both counters = 0, head = tail = 0.
- Reset mid-operation:
  - All entries are discarded.
  - No `bht_write` or `mispredict` is produced in the following cycle, even if `resolve_valid` was high with reset.
- `enq_ready`, `empty`, `full` and `count` are registered-state decodes. They change only in the cycle after an accepted enqueue, resolve or squash.
- Resolve latency: a resolve accepted at edge N produces `bht_write`, `bht_write_pc`, `bht_taken` and `mispredict` valid for exactly cycle N+1.
- Back-to-back resolves give consecutive single-cycle write pulses, one per cycle.
- Counters reflect a resolve from cycle N+1 onward.
- The BHT samples `write` at its own clock edge at the end of cycle N+1. No handshake back from the BHT; a write is never stalled.

## Test plan
- Reset:
  - Assert reset 2 cycles with `enq_valid` = `resolve_valid` = 1.
  - Required: `empty` = 1, `enq_ready` = 1, `count` = 0, `bht_write` = 0, `mispredict` = 0, counters = 0.
- Correct prediction:
  - Enqueue pc 16'h1000, pred 1; next cycle resolve taken 1.
  - Required, following cycle: `bht_write` = 1, `bht_write_pc` = 16'h1000, `bht_taken` = 1, `mispredict` = 0, `branch_count` = 1, `empty` = 1.
- Full boundary and wrap:
  - With DEPTH = 4, enqueue 0x3000, 0x3002, 0x3004, 0x3006; `full` = 1.
  - Enqueue 0x3008: dropped.
  - Resolve 5 times with matching outcomes.
  - Required: exactly 4 writes with pcs 0x3000 to 0x3006 in order; 5th resolve is ignored.
  - Repeat twice to exercise pointer wrap.
- Mispredict squash:
  - Queue 0x2000 (pred 0), 0x2002, 0x2004.
  - Resolve taken 1 while enqueuing 0x2006.
  - Required, next cycle: `mispredict` = 1, write pc 0x2000, taken 1, `count` = 0, `mispredict_count` = 1; 0x2006 is absent.
- Simultaneous enqueue and resolve:
  - Queue holds 2 entries; enqueue and matching resolve in the same cycle.
  - Required: `count` stays 2, write of the old head, new entry is resolved last.
- Reset mid-operation:
  - 3 entries queued; assert reset with `resolve_valid` = 1.
  - Required, next cycle: `bht_write` = 0, `empty` = 1, counters = 0.
